// File: rtl/vgatiming.sv
// vgatiming: runtime-programmable VGA raster timing generator.
// Scan-request outputs are decoded straight from the raster counters; the pin
// outputs (de/hsync/vsync) trail them by a LOOKAHEAD-deep delay line so the
// fetch logic can run ahead of the DAC. New modes are staged in a one-entry
// shadow slot and applied only on the wrap to (0,0).
module vgatiming #(
  parameter int unsigned XW        = 12,
  parameter int unsigned YW        = 11,
  parameter int unsigned LOOKAHEAD = 2,
  parameter bit          HPOL      = 1'b1,
  parameter bit          VPOL      = 1'b1,
  parameter int unsigned DEF_W     = 1280,
  parameter int unsigned DEF_HFP   = 48,
  parameter int unsigned DEF_HSP   = 112,
  parameter int unsigned DEF_HBP   = 248,
  parameter int unsigned DEF_H     = 1024,
  parameter int unsigned DEF_VFP   = 1,
  parameter int unsigned DEF_VSP   = 3,
  parameter int unsigned DEF_VBP   = 38
) (
  input  logic          pxclk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [XW-1:0] cfg_w,
  input  logic [XW-1:0] cfg_hfp,
  input  logic [XW-1:0] cfg_hsp,
  input  logic [XW-1:0] cfg_hbp,
  input  logic [YW-1:0] cfg_h,
  input  logic [YW-1:0] cfg_vfp,
  input  logic [YW-1:0] cfg_vsp,
  input  logic [YW-1:0] cfg_vbp,
  output logic          req_inframe,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          de,
  output logic          hsync,
  output logic          vsync
);

  // Sums carry one extra bit so oversized modes are detectable rather than aliasing.
  localparam int unsigned XS = XW + 1;
  localparam int unsigned YS = YW + 1;

  // Active mode
  logic [XW-1:0] w_q, hfp_q, hsp_q, hbp_q;
  logic [YW-1:0] h_q, vfp_q, vsp_q, vbp_q;

  // Shadow (pending) mode
  logic [XW-1:0] sw_q, shfp_q, shsp_q, shbp_q;
  logic [YW-1:0] sh_q, svfp_q, svsp_q, svbp_q;
  logic          pending_q, pending_d;

  // Raster counters
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Horizontal/vertical boundaries of the active mode
  logic [XS-1:0] h_sync_start, h_sync_end, h_total;
  logic [YS-1:0] v_sync_start, v_sync_end, v_total;
  logic [XS-1:0] x_ext;
  logic [YS-1:0] y_ext;
  logic          x_last, y_last;
  logic          accept, apply;

  // Raw decode and its delayed copies
  logic vis, hs_raw, vs_raw;
  logic vis_dly, hs_dly, vs_dly;

  // Boundary sums for the active mode
  always_comb begin
    h_sync_start = XS'(w_q) + XS'(hfp_q);
    h_sync_end   = h_sync_start + XS'(hsp_q);
    h_total      = h_sync_end + XS'(hbp_q);
    v_sync_start = YS'(h_q) + YS'(vfp_q);
    v_sync_end   = v_sync_start + YS'(vsp_q);
    v_total      = v_sync_end + YS'(vbp_q);
  end

  // End-of-line / end-of-frame detection; an oversized total never matches, so
  // the counters simply wrap at their natural width.
  always_comb begin
    x_ext  = {1'b0, x_q};
    y_ext  = {1'b0, y_q};
    x_last = (x_ext == (h_total - XS'(1)));
    y_last = (y_ext == (v_total - YS'(1)));
  end

  // Counter next-state
  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_last) begin
      x_d = '0;
      if (y_last) begin
        y_d = '0;
      end else begin
        y_d = y_q + YW'(1);
      end
    end
  end

  // Handshake: accept only into an empty slot, apply on the (0,0) wrap.
  always_comb begin
    accept    = cfg_valid && !pending_q;
    apply     = pending_q && x_last && y_last;
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  // Raster counter registers
  always_ff @(posedge pxclk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Pending flag; reset discards any staged mode
  always_ff @(posedge pxclk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Shadow capture on a handshake transfer
  always_ff @(posedge pxclk) begin
    if (rst) begin
      sw_q   <= XW'(DEF_W);
      shfp_q <= XW'(DEF_HFP);
      shsp_q <= XW'(DEF_HSP);
      shbp_q <= XW'(DEF_HBP);
      sh_q   <= YW'(DEF_H);
      svfp_q <= YW'(DEF_VFP);
      svsp_q <= YW'(DEF_VSP);
      svbp_q <= YW'(DEF_VBP);
    end else if (accept) begin
      sw_q   <= cfg_w;
      shfp_q <= cfg_hfp;
      shsp_q <= cfg_hsp;
      shbp_q <= cfg_hbp;
      sh_q   <= cfg_h;
      svfp_q <= cfg_vfp;
      svsp_q <= cfg_vsp;
      svbp_q <= cfg_vbp;
    end
  end

  // Active mode load: defaults on reset, shadow on frame wrap
  always_ff @(posedge pxclk) begin
    if (rst) begin
      w_q   <= XW'(DEF_W);
      hfp_q <= XW'(DEF_HFP);
      hsp_q <= XW'(DEF_HSP);
      hbp_q <= XW'(DEF_HBP);
      h_q   <= YW'(DEF_H);
      vfp_q <= YW'(DEF_VFP);
      vsp_q <= YW'(DEF_VSP);
      vbp_q <= YW'(DEF_VBP);
    end else if (apply) begin
      w_q   <= sw_q;
      hfp_q <= shfp_q;
      hsp_q <= shsp_q;
      hbp_q <= shbp_q;
      h_q   <= sh_q;
      vfp_q <= svfp_q;
      vsp_q <= svsp_q;
      vbp_q <= svbp_q;
    end
  end

  // Raw decode from the counters
  always_comb begin
    vis    = (x_q < w_q) && (y_q < h_q);
    hs_raw = (x_ext >= h_sync_start) && (x_ext < h_sync_end);
    vs_raw = (y_ext >= v_sync_start) && (y_ext < v_sync_end);
  end

  // Zero-latency scan-request outputs
  always_comb begin
    cfg_ready   = !pending_q;
    req_inframe = vis;
    req_x       = vis ? x_q : '0;
    req_y       = vis ? y_q : '0;
    line_start  = (x_q == '0);
    frame_start = (x_q == '0) && (y_q == '0);
  end

  // Pin-side delay line; stages reset to the inactive level
  generate
    if (LOOKAHEAD == 0) begin : g_direct
      assign vis_dly = vis;
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
    end else begin : g_delay
      logic [LOOKAHEAD-1:0] vis_q, hs_q, vs_q;

      // Shift raw decode toward the pins, one stage per cycle
      always_ff @(posedge pxclk) begin
        if (rst) begin
          vis_q <= '0;
          hs_q  <= '0;
          vs_q  <= '0;
        end else begin
          vis_q[0] <= vis;
          hs_q[0]  <= hs_raw;
          vs_q[0]  <= vs_raw;
          for (int i = 1; i < int'(LOOKAHEAD); i++) begin
            vis_q[i] <= vis_q[i-1];
            hs_q[i]  <= hs_q[i-1];
            vs_q[i]  <= vs_q[i-1];
          end
        end
      end

      assign vis_dly = vis_q[LOOKAHEAD-1];
      assign hs_dly  = hs_q[LOOKAHEAD-1];
      assign vs_dly  = vs_q[LOOKAHEAD-1];
    end
  endgenerate

  // Polarity applied at the pins
  always_comb begin
    de    = vis_dly;
    hsync = ~(hs_dly ^ HPOL);
    vsync = ~(vs_dly ^ VPOL);
  end

endmodule

// File: tb/tb_vgatiming.sv
// Bench for vgatiming: two instances (direct path / positive sync, and
// 2-cycle lookahead / negative sync) driven by the same stimulus. A per-cycle
// reference derived from frame-relative time plus hand-computed point
// expectations feed queues that a negedge monitor drains.
module tb_vgatiming;

  localparam int unsigned XW = 12;
  localparam int unsigned YW = 11;

  typedef struct {
    int w, hfp, hsp, hbp, h, vfp, vsp, vbp;
  } mode_t;

  typedef struct {
    int inf, rx, ry, ls, fs, rdy;
    int a_de, a_hs, a_vs, b_de, b_hs, b_vs;
  } exp_t;

  typedef struct {
    int unsigned at;
    int          sig;
    int          val;
  } pt_t;

  localparam int S_A_INF = 0;
  localparam int S_A_HS  = 1;
  localparam int S_A_VS  = 2;
  localparam int S_A_FS  = 3;
  localparam int S_B_DE  = 4;
  localparam int S_B_HS  = 5;
  localparam int S_B_VS  = 6;
  localparam int S_RDY   = 7;

  logic pxclk = 1'b0;
  always #5 pxclk = ~pxclk;

  logic          rst;
  logic          cfg_valid;
  logic [XW-1:0] cfg_w, cfg_hfp, cfg_hsp, cfg_hbp;
  logic [YW-1:0] cfg_h, cfg_vfp, cfg_vsp, cfg_vbp;

  logic          rdy_a, inf_a, ls_a, fs_a, de_a, hs_a, vs_a;
  logic [XW-1:0] rx_a;
  logic [YW-1:0] ry_a;
  logic          rdy_b, inf_b, ls_b, fs_b, de_b, hs_b, vs_b;
  logic [XW-1:0] rx_b;
  logic [YW-1:0] ry_b;

  vgatiming #(
    .XW(XW), .YW(YW), .LOOKAHEAD(0), .HPOL(1'b1), .VPOL(1'b1),
    .DEF_W(8), .DEF_HFP(2), .DEF_HSP(3), .DEF_HBP(3),
    .DEF_H(4), .DEF_VFP(1), .DEF_VSP(1), .DEF_VBP(2)
  ) u_a (
    .pxclk(pxclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_a),
    .cfg_w(cfg_w), .cfg_hfp(cfg_hfp), .cfg_hsp(cfg_hsp), .cfg_hbp(cfg_hbp),
    .cfg_h(cfg_h), .cfg_vfp(cfg_vfp), .cfg_vsp(cfg_vsp), .cfg_vbp(cfg_vbp),
    .req_inframe(inf_a), .req_x(rx_a), .req_y(ry_a),
    .line_start(ls_a), .frame_start(fs_a),
    .de(de_a), .hsync(hs_a), .vsync(vs_a)
  );

  vgatiming #(
    .XW(XW), .YW(YW), .LOOKAHEAD(2), .HPOL(1'b0), .VPOL(1'b0),
    .DEF_W(8), .DEF_HFP(2), .DEF_HSP(3), .DEF_HBP(3),
    .DEF_H(4), .DEF_VFP(1), .DEF_VSP(1), .DEF_VBP(2)
  ) u_b (
    .pxclk(pxclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_b),
    .cfg_w(cfg_w), .cfg_hfp(cfg_hfp), .cfg_hsp(cfg_hsp), .cfg_hbp(cfg_hbp),
    .cfg_h(cfg_h), .cfg_vfp(cfg_vfp), .cfg_vsp(cfg_vsp), .cfg_vbp(cfg_vbp),
    .req_inframe(inf_b), .req_x(rx_b), .req_y(ry_b),
    .line_start(ls_b), .frame_start(fs_b),
    .de(de_b), .hsync(hs_b), .vsync(vs_b)
  );

  int unsigned cyc = 0;
  always @(posedge pxclk) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  exp_t exq[$];
  pt_t  pq[$];

  // Reference state: active/shadow mode, pending flag, cycles into frame, pin history
  mode_t m, sh, defm;
  bit    pend;
  int    fc;
  bit    d1v, d2v, d1h, d2h, d1s, d2s;

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp_v);
    end
  endtask

  function automatic int get_sig(input int s);
    case (s)
      S_A_INF: return int'(inf_a);
      S_A_HS:  return int'(hs_a);
      S_A_VS:  return int'(vs_a);
      S_A_FS:  return int'(fs_a);
      S_B_DE:  return int'(de_b);
      S_B_HS:  return int'(hs_b);
      S_B_VS:  return int'(vs_b);
      default: return int'(rdy_a);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_A_INF: return "pt_a_inframe";
      S_A_HS:  return "pt_a_hsync";
      S_A_VS:  return "pt_a_vsync";
      S_A_FS:  return "pt_a_frame_start";
      S_B_DE:  return "pt_b_de";
      S_B_HS:  return "pt_b_hsync";
      S_B_VS:  return "pt_b_vsync";
      default: return "pt_cfg_ready";
    endcase
  endfunction

  // Hand-computed point expectation, kept sorted by cycle
  function automatic void expect_at(input int unsigned at, input int sig, input int val);
    pt_t p;
    int  i;
    p.at = at; p.sig = sig; p.val = val;
    i = 0;
    while (i < pq.size() && pq[i].at <= at) i++;
    pq.insert(i, p);
  endfunction

  function automatic void decode(input mode_t md, input int f,
                                 output int x, output int y,
                                 output bit v, output bit hs, output bit vs);
    int tw;
    tw = md.w + md.hfp + md.hsp + md.hbp;
    x  = f % tw;
    y  = f / tw;
    v  = (x < md.w) && (y < md.h);
    hs = (x >= md.w + md.hfp) && (x < md.w + md.hfp + md.hsp);
    vs = (y >= md.h + md.vfp) && (y < md.h + md.vfp + md.vsp);
  endfunction

  // One clock: advance the reference with the inputs seen at the edge, queue expectations
  task automatic tick();
    int   x, y, tw, th;
    bit   v, hs, vs, old_pend;
    exp_t e;
    @(posedge pxclk);
    #1;
    decode(m, fc, x, y, v, hs, vs);
    if (rst) begin
      fc = 0; m = defm; pend = 1'b0;
      d1v = 0; d2v = 0; d1h = 0; d2h = 0; d1s = 0; d2s = 0;
    end else begin
      d2v = d1v; d1v = v;
      d2h = d1h; d1h = hs;
      d2s = d1s; d1s = vs;
      old_pend = pend;
      tw = m.w + m.hfp + m.hsp + m.hbp;
      th = m.h + m.vfp + m.vsp + m.vbp;
      if (cfg_valid && !old_pend) begin
        sh = '{int'(cfg_w), int'(cfg_hfp), int'(cfg_hsp), int'(cfg_hbp),
               int'(cfg_h), int'(cfg_vfp), int'(cfg_vsp), int'(cfg_vbp)};
        pend = 1'b1;
      end
      if (fc + 1 == tw * th) begin
        fc = 0;
        if (old_pend) begin
          m = sh; pend = 1'b0;
        end
      end else begin
        fc++;
      end
    end
    decode(m, fc, x, y, v, hs, vs);
    e.inf  = v;
    e.rx   = v ? x : 0;
    e.ry   = v ? y : 0;
    e.ls   = (x == 0);
    e.fs   = (fc == 0);
    e.rdy  = !pend;
    e.a_de = v;  e.a_hs = hs;   e.a_vs = vs;
    e.b_de = d2v; e.b_hs = !d2h; e.b_vs = !d2s;
    exq.push_back(e);
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) tick();
  endtask

  task automatic drive_cfg(input mode_t md, input bit valid);
    cfg_w   = XW'(md.w);   cfg_hfp = XW'(md.hfp);
    cfg_hsp = XW'(md.hsp); cfg_hbp = XW'(md.hbp);
    cfg_h   = YW'(md.h);   cfg_vfp = YW'(md.vfp);
    cfg_vsp = YW'(md.vsp); cfg_vbp = YW'(md.vbp);
    cfg_valid = valid;
  endtask

  // Monitor: compare every presented cycle against the queued expectations
  always @(negedge pxclk) begin : mon
    exp_t e;
    pt_t  p;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      check("inframe_a", int'(inf_a), e.inf);
      check("inframe_b", int'(inf_b), e.inf);
      check("req_x_a", int'(rx_a), e.rx);
      check("req_x_b", int'(rx_b), e.rx);
      check("req_y_a", int'(ry_a), e.ry);
      check("req_y_b", int'(ry_b), e.ry);
      check("line_start_a", int'(ls_a), e.ls);
      check("line_start_b", int'(ls_b), e.ls);
      check("frame_start_a", int'(fs_a), e.fs);
      check("frame_start_b", int'(fs_b), e.fs);
      check("cfg_ready_a", int'(rdy_a), e.rdy);
      check("cfg_ready_b", int'(rdy_b), e.rdy);
      check("de_a", int'(de_a), e.a_de);
      check("hsync_a", int'(hs_a), e.a_hs);
      check("vsync_a", int'(vs_a), e.a_vs);
      check("de_b", int'(de_b), e.b_de);
      check("hsync_b", int'(hs_b), e.b_hs);
      check("vsync_b", int'(vs_b), e.b_vs);
    end
    while (pq.size() > 0 && pq[0].at <= cyc) begin
      p = pq.pop_front();
      if (p.at < cyc) check("pt_missed", int'(p.at), int'(cyc));
      else check(sig_name(p.sig), get_sig(p.sig), p.val);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int unsigned b, w0, d0, f0, r_at, e0;
    mode_t m4, m2, mdeg, mpend;
    defm  = '{8, 2, 3, 3, 4, 1, 1, 2};
    m4    = '{4, 2, 3, 3, 4, 1, 1, 2};
    m2    = '{2, 1, 1, 1, 2, 1, 1, 1};
    mdeg  = '{8, 2, 0, 3, 0, 1, 1, 2};
    mpend = '{4, 1, 1, 1, 2, 1, 1, 1};
    m = defm; sh = defm; pend = 1'b0; fc = 0;
    d1v = 0; d2v = 0; d1h = 0; d2h = 0; d1s = 0; d2s = 0;

    rst = 1'b1;
    drive_cfg(defm, 1'b0);

    // Reset hold and base mode (TW=16, TH=8)
    b = cyc + 3;
    expect_at(b, S_B_DE, 0);    expect_at(b, S_B_HS, 1);   expect_at(b, S_B_VS, 1);
    expect_at(b, S_A_FS, 1);    expect_at(b, S_RDY, 1);
    expect_at(b + 7, S_A_INF, 1);  expect_at(b + 8, S_A_INF, 0);
    expect_at(b + 55, S_A_INF, 1); expect_at(b + 64, S_A_INF, 0);
    expect_at(b + 9, S_A_HS, 0);   expect_at(b + 10, S_A_HS, 1);
    expect_at(b + 12, S_A_HS, 1);  expect_at(b + 13, S_A_HS, 0);
    expect_at(b + 79, S_A_VS, 0);  expect_at(b + 80, S_A_VS, 1);
    expect_at(b + 95, S_A_VS, 1);  expect_at(b + 96, S_A_VS, 0);
    expect_at(b + 127, S_A_FS, 0); expect_at(b + 128, S_A_FS, 1);
    expect_at(b + 256, S_A_FS, 1);
    expect_at(b + 1, S_B_DE, 0);   expect_at(b + 2, S_B_DE, 1);
    expect_at(b + 9, S_B_DE, 1);   expect_at(b + 10, S_B_DE, 0);
    expect_at(b + 11, S_B_HS, 1);  expect_at(b + 12, S_B_HS, 0);
    expect_at(b + 14, S_B_HS, 0);  expect_at(b + 15, S_B_HS, 1);
    expect_at(b + 81, S_B_VS, 1);  expect_at(b + 82, S_B_VS, 0);
    expect_at(b + 97, S_B_VS, 0);  expect_at(b + 98, S_B_VS, 1);
    repeat (3) tick();
    rst = 1'b0;

    // Reload to W=4 mid-frame; a second offer while pending must be ignored
    w0 = b + 384;
    expect_at(b + 296, S_RDY, 1);  expect_at(b + 297, S_RDY, 0);
    expect_at(b + 311, S_A_INF, 1);
    expect_at(w0 - 1, S_RDY, 0);   expect_at(w0, S_RDY, 1);
    expect_at(w0, S_A_FS, 1);      expect_at(w0 + 3, S_A_INF, 1);
    expect_at(w0 + 4, S_A_INF, 0); expect_at(w0 + 12, S_A_INF, 1);
    expect_at(w0 + 96, S_A_FS, 1); expect_at(w0 + 128, S_A_FS, 0);
    run_to(b + 296);
    drive_cfg(m4, 1'b1);
    tick();
    drive_cfg(m2, 1'b1);
    repeat (20) tick();
    drive_cfg(m2, 1'b0);

    // Degenerate mode H=0, HSP=0 (TW=13, TH=4)
    d0 = w0 + 192;
    expect_at(w0 + 96, S_A_INF, 1); expect_at(w0 + 101, S_RDY, 0);
    expect_at(d0, S_A_INF, 0);      expect_at(d0 + 1, S_A_INF, 0);
    expect_at(d0 + 10, S_A_HS, 0);  expect_at(d0 + 12, S_A_VS, 0);
    expect_at(d0 + 13, S_A_VS, 1);  expect_at(d0 + 25, S_A_VS, 1);
    expect_at(d0 + 26, S_A_VS, 0);  expect_at(d0 + 65, S_A_VS, 1);
    expect_at(d0 + 2, S_B_DE, 0);   expect_at(d0 + 12, S_B_HS, 1);
    expect_at(d0 + 14, S_B_VS, 1);  expect_at(d0 + 15, S_B_VS, 0);
    expect_at(d0 + 52, S_A_FS, 1);
    run_to(w0 + 100);
    drive_cfg(mdeg, 1'b1);
    tick();
    drive_cfg(mdeg, 1'b0);

    // Reset at (5,2) with a mode pending: pending mode must be dropped
    f0   = d0 + 104;
    r_at = f0 + 31;
    expect_at(f0 + 6, S_RDY, 0);
    expect_at(r_at + 1, S_B_DE, 0); expect_at(r_at + 1, S_B_HS, 1);
    expect_at(r_at + 1, S_B_VS, 1); expect_at(r_at + 1, S_RDY, 1);
    run_to(f0 + 5);
    drive_cfg(mpend, 1'b1);
    tick();
    drive_cfg(mpend, 1'b0);
    run_to(r_at);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    e0 = cyc;
    expect_at(e0, S_A_INF, 1);       expect_at(e0, S_A_FS, 1);
    expect_at(e0, S_RDY, 1);         expect_at(e0 + 7, S_A_INF, 1);
    expect_at(e0 + 8, S_A_INF, 0);   expect_at(e0 + 128, S_A_FS, 1);
    run_to(e0 + 140);

    repeat (2) @(negedge pxclk);
    #1;
    check("points_left", pq.size(), 0);
    check("expected_left", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
